// File: rtl/gf180mcu_ocd_io__pad_pkg.sv
// Shared types, cfg_word field layout and decode helpers for the pad sequencer.
package gf180mcu_ocd_io__pad_pkg;

    localparam int unsigned CFG_W    = 8;
    localparam int unsigned DIR_LSB  = 0;
    localparam int unsigned DIR_W    = 2;
    localparam int unsigned PULL_LSB = 2;
    localparam int unsigned PULL_W   = 2;
    localparam int unsigned DRV_LSB  = 4;
    localparam int unsigned DRV_W    = 2;
    localparam int unsigned SL_BIT   = 6;
    localparam int unsigned CS_BIT   = 7;

    localparam logic [DIR_W-1:0] DIR_OFF   = 2'b00;
    localparam logic [DIR_W-1:0] DIR_IN    = 2'b01;
    localparam logic [DIR_W-1:0] DIR_OUT   = 2'b10;
    localparam logic [DIR_W-1:0] DIR_BIDIR = 2'b11;

    localparam logic [PULL_W-1:0] PULL_NONE    = 2'b00;
    localparam logic [PULL_W-1:0] PULL_UP      = 2'b01;
    localparam logic [PULL_W-1:0] PULL_DOWN    = 2'b10;
    localparam logic [PULL_W-1:0] PULL_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DRAIN      = 2'd1,
        APPLY_WAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic ie;
        logic oe;
        logic pu;
        logic pd;
    } pad_ctl_t;

    // Direction and pull fields to the per-pad enable bits.
    function automatic pad_ctl_t decode_cfg(input logic [CFG_W-1:0] w);
        pad_ctl_t         c;
        logic [DIR_W-1:0]  dir;
        logic [PULL_W-1:0] pull;
        dir  = w[DIR_LSB +: DIR_W];
        pull = w[PULL_LSB +: PULL_W];
        c.ie = (dir == DIR_IN)  || (dir == DIR_BIDIR);
        c.oe = (dir == DIR_OUT) || (dir == DIR_BIDIR);
        c.pu = (pull == PULL_UP);
        c.pd = (pull == PULL_DOWN);
        return c;
    endfunction

    function automatic logic pull_illegal(input logic [CFG_W-1:0] w);
        return w[PULL_LSB +: PULL_W] == PULL_ILLEGAL;
    endfunction

endpackage

// File: rtl/gf180mcu_ocd_io__settle_cnt.sv
// Settle-phase counter: loads SETTLE-1, counts down to zero and holds there.
module gf180mcu_ocd_io__settle_cnt
    import gf180mcu_ocd_io__pad_pkg::*;
#(
    parameter int unsigned SETTLE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero_c
);

    localparam int unsigned   CW       = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign zero_c = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (dec && !zero_c) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gf180mcu_ocd_io__pad_seq_ctrl.sv
// Break-before-make configuration sequencer for a bank of bi_t pads, with a global
// safe-state override that turns every output driver off.
module gf180mcu_ocd_io__pad_seq_ctrl
    import gf180mcu_ocd_io__pad_pkg::*;
#(
    parameter int unsigned NPADS  = 16,
    parameter int unsigned IDXW   = (NPADS > 1) ? $clog2(NPADS) : 1,
    parameter int unsigned SETTLE = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 safe_i,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [IDXW-1:0]      cfg_idx,
    input  logic [CFG_W-1:0]     cfg_word,
    output logic                 done,
    output logic                 err,
    output logic [IDXW-1:0]      busy_idx,
    output logic [NPADS-1:0]     pad_cs,
    output logic [NPADS-1:0]     pad_sl,
    output logic [NPADS-1:0]     pad_ie,
    output logic [NPADS-1:0]     pad_oe,
    output logic [NPADS-1:0]     pad_pu,
    output logic [NPADS-1:0]     pad_pd,
    output logic [2*NPADS-1:0]   pad_pdrv
);

    state_e             state_q, state_d;
    logic               safe_q;
    logic               out_en_q;
    logic [CFG_W-1:0]   req_q, req_d;
    logic [IDXW-1:0]    busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [NPADS-1:0]   cs_q, cs_d, sl_q, sl_d, ie_q, ie_d;
    logic [NPADS-1:0]   oe_q, oe_d, pu_q, pu_d, pd_q, pd_d;
    logic [2*NPADS-1:0] pdrv_q, pdrv_d;
    logic [CFG_W-1:0]   shadow_q [NPADS];
    logic [CFG_W-1:0]   shadow_d [NPADS];

    logic     cnt_load;
    logic     cnt_dec;
    logic     cnt_zero_c;
    logic     accept_c;
    logic     reject_c;
    logic     abort_c;
    pad_ctl_t req_ctl_c;
    pad_ctl_t shd_ctl_c;

    gf180mcu_ocd_io__settle_cnt #(
        .SETTLE (SETTLE)
    ) u_settle_cnt (
        .clk    (CLK),
        .rst    (RST),
        .load   (cnt_load),
        .dec    (cnt_dec),
        .zero_c (cnt_zero_c)
    );

    // Ready comes from registered state only, so a same-cycle safe_i can never race an accept.
    assign cfg_ready = out_en_q & (state_q == IDLE) & ~safe_q;
    assign accept_c  = cfg_valid & cfg_ready;
    assign reject_c  = pull_illegal(cfg_word) | (32'(cfg_idx) >= NPADS);
    assign abort_c   = safe_q & (state_q != IDLE);

    assign done     = done_q;
    assign err      = err_q;
    assign busy_idx = busy_q;
    assign pad_cs   = cs_q;
    assign pad_sl   = sl_q;
    assign pad_ie   = ie_q;
    assign pad_oe   = oe_q;
    assign pad_pu   = pu_q;
    assign pad_pd   = pd_q;
    assign pad_pdrv = pdrv_q;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        cs_d      = cs_q;
        sl_d      = sl_q;
        ie_d      = ie_q;
        oe_d      = oe_q;
        pu_d      = pu_q;
        pd_d      = pd_q;
        pdrv_d    = pdrv_q;
        shadow_d  = shadow_q;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        req_ctl_c = decode_cfg(req_q);
        shd_ctl_c = '0;

        if (abort_c) begin
            // Aborted pad is left off; its shadow records what is actually on the pins.
            state_d          = IDLE;
            done_d           = 1'b1;
            err_d            = 1'b1;
            busy_d           = '0;
            ie_d[busy_q]     = 1'b0;
            shadow_d[busy_q] = {cs_q[busy_q], sl_q[busy_q], pdrv_q[{busy_q, 1'b0} +: 2],
                                pd_q[busy_q], pu_q[busy_q], DIR_OFF};
        end else begin
            case (state_q)
                IDLE: begin
                    // Idle output enables always mirror the shadow, which also restores them after safe.
                    for (int i = 0; i < NPADS; i++) begin
                        shd_ctl_c = decode_cfg(shadow_q[i]);
                        oe_d[i]   = shd_ctl_c.oe;
                    end
                    if (accept_c) begin
                        if (reject_c) begin
                            done_d = 1'b1;
                            err_d  = 1'b1;
                        end else begin
                            oe_d[cfg_idx] = 1'b0;
                            req_d         = cfg_word;
                            busy_d        = cfg_idx;
                            cnt_load      = 1'b1;
                            state_d       = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_zero_c) begin
                        cs_d[busy_q]                    = req_q[CS_BIT];
                        sl_d[busy_q]                    = req_q[SL_BIT];
                        ie_d[busy_q]                    = req_ctl_c.ie;
                        pu_d[busy_q]                    = req_ctl_c.pu;
                        pd_d[busy_q]                    = req_ctl_c.pd;
                        pdrv_d[{busy_q, 1'b0} +: 2]     = req_q[DRV_LSB +: DRV_W];
                        cnt_load                        = 1'b1;
                        state_d                         = APPLY_WAIT;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                APPLY_WAIT: begin
                    if (cnt_zero_c) begin
                        oe_d[busy_q]     = req_ctl_c.oe;
                        shadow_d[busy_q] = req_q;
                        done_d           = 1'b1;
                        busy_d           = '0;
                        state_d          = IDLE;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (safe_q) begin
            oe_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            safe_q   <= 1'b0;
            out_en_q <= 1'b0;
            req_q    <= '0;
            busy_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cs_q     <= '0;
            sl_q     <= '0;
            ie_q     <= '0;
            oe_q     <= '0;
            pu_q     <= '0;
            pd_q     <= '0;
            pdrv_q   <= '0;
            for (int i = 0; i < NPADS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            safe_q   <= safe_i;
            out_en_q <= 1'b1;
            req_q    <= req_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            cs_q     <= cs_d;
            sl_q     <= sl_d;
            ie_q     <= ie_d;
            oe_q     <= oe_d;
            pu_q     <= pu_d;
            pd_q     <= pd_d;
            pdrv_q   <= pdrv_d;
            for (int i = 0; i < NPADS; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

endmodule

// File: tb/tb_gf180mcu_ocd_io__pad_seq_ctrl.sv
// Directed bench for the pad sequencer (12 pads so that an out-of-range index is encodable).
module tb_gf180mcu_ocd_io__pad_seq_ctrl;

    localparam int unsigned NPADS  = 12;
    localparam int unsigned IDXW   = 4;
    localparam int unsigned SETTLE = 4;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               safe_i = 1'b0;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [IDXW-1:0]    cfg_idx = '0;
    logic [7:0]         cfg_word = '0;
    logic               done, err;
    logic [IDXW-1:0]    busy_idx;
    logic [NPADS-1:0]   pad_cs, pad_sl, pad_ie, pad_oe, pad_pu, pad_pd;
    logic [2*NPADS-1:0] pad_pdrv;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected pad state, updated by hand after each scenario.
    logic [NPADS-1:0]   e_cs, e_sl, e_ie, e_oe, e_pu, e_pd;
    logic [2*NPADS-1:0] e_pdrv;

    gf180mcu_ocd_io__pad_seq_ctrl #(
        .NPADS  (NPADS),
        .SETTLE (SETTLE)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .safe_i    (safe_i),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_idx   (cfg_idx),
        .cfg_word  (cfg_word),
        .done      (done),
        .err       (err),
        .busy_idx  (busy_idx),
        .pad_cs    (pad_cs),
        .pad_sl    (pad_sl),
        .pad_ie    (pad_ie),
        .pad_oe    (pad_oe),
        .pad_pu    (pad_pu),
        .pad_pd    (pad_pd),
        .pad_pdrv  (pad_pdrv)
    );

    always #5 CLK = ~CLK;

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Present one request for a single edge; returns in cycle T+1.
    task automatic issue(input logic [IDXW-1:0] idx, input logic [7:0] w);
        cfg_idx   = idx;
        cfg_word  = w;
        cfg_valid = 1'b1;
        cyc(1);
        cfg_valid = 1'b0;
    endtask

    task automatic check_pads(input string name);
        n_checks++;
        if ({pad_cs, pad_sl, pad_ie, pad_oe, pad_pu, pad_pd, pad_pdrv} !==
            {e_cs, e_sl, e_ie, e_oe, e_pu, e_pd, e_pdrv}) begin
            n_fail++;
            $display("FAIL %s: cs=%h sl=%h ie=%h oe=%h pu=%h pd=%h pdrv=%h want cs=%h sl=%h ie=%h oe=%h pu=%h pd=%h pdrv=%h",
                     name, pad_cs, pad_sl, pad_ie, pad_oe, pad_pu, pad_pd, pad_pdrv,
                     e_cs, e_sl, e_ie, e_oe, e_pu, e_pd, e_pdrv);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        cyc(2);
        e_cs = '0; e_sl = '0; e_ie = '0; e_oe = '0; e_pu = '0; e_pd = '0; e_pdrv = '0;
        check_pads("reset_pads");
        n_checks++;
        if ({done, err, busy_idx, cfg_ready} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctl: got %b want 0000000", {done, err, busy_idx, cfg_ready});
        end
        RST = 1'b0;
        cyc(1);
        n_checks++;
        if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
    endtask

    task automatic test_basic_seq();
        issue(4'd3, 8'h16);
        n_checks++;
        if ({pad_oe[3], busy_idx, cfg_ready} !== {1'b0, 4'd3, 1'b0}) begin
            n_fail++; $display("FAIL t1_t1: oe3/busy/ready=%b want 000110", {pad_oe[3], busy_idx, cfg_ready});
        end
        cyc(3);
        n_checks++;
        if ({pad_pu[3], pad_pdrv[7:6]} !== 3'b000) begin
            n_fail++; $display("FAIL t1_t4_early: pu3/pdrv=%b want 000", {pad_pu[3], pad_pdrv[7:6]});
        end
        cyc(1);
        n_checks++;
        if ({pad_pu[3], pad_pdrv[7:6], pad_oe[3]} !== 4'b1010) begin
            n_fail++; $display("FAIL t1_t5_static: pu3/pdrv/oe3=%b want 1010", {pad_pu[3], pad_pdrv[7:6], pad_oe[3]});
        end
        cyc(3);
        n_checks++;
        if ({pad_oe[3], done} !== 2'b00) begin
            n_fail++; $display("FAIL t1_t8: oe3/done=%b want 00", {pad_oe[3], done});
        end
        cyc(1);
        n_checks++;
        if ({pad_oe[3], done, err, cfg_ready, busy_idx} !== {4'b1101, 4'd0}) begin
            n_fail++; $display("FAIL t1_t9: oe3/done/err/ready/busy=%b want 11010000", {pad_oe[3], done, err, cfg_ready, busy_idx});
        end
        cyc(1);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL t1_done_pulse: got %b want 0", done); end
        e_oe = 12'h008; e_pu = 12'h008; e_pdrv = 24'h000040;
        check_pads("t1_final");
    endtask

    task automatic test_reject();
        issue(4'd2, 8'h0E);
        n_checks++;
        if ({done, err, cfg_ready} !== 3'b111) begin
            n_fail++; $display("FAIL t2_pull: done/err/ready=%b want 111", {done, err, cfg_ready});
        end
        check_pads("t2_pull_pads");
        issue(4'(NPADS), 8'h02);
        n_checks++;
        if ({done, err} !== 2'b11) begin
            n_fail++; $display("FAIL t2_idx: done/err=%b want 11", {done, err});
        end
        cyc(1);
        n_checks++;
        if ({done, err, busy_idx} !== 6'b0) begin
            n_fail++; $display("FAIL t2_after: done/err/busy=%b want 000000", {done, err, busy_idx});
        end
        check_pads("t2_idx_pads");
    endtask

    task automatic test_out_to_in();
        issue(4'd5, 8'h2A);
        cyc(8);
        n_checks++;
        if ({done, pad_oe[5], pad_pd[5]} !== 3'b111) begin
            n_fail++; $display("FAIL t3_setup: done/oe5/pd5=%b want 111", {done, pad_oe[5], pad_pd[5]});
        end
        e_oe = 12'h028; e_pd = 12'h020; e_pdrv = 24'h000840;
        check_pads("t3_setup_pads");
        cyc(1);
        issue(4'd5, 8'h01);
        for (int k = 1; k <= 9; k++) begin
            n_checks++;
            if (pad_oe[5] && !pad_pd[5]) begin
                n_fail++; $display("FAIL t3_overlap: cycle T+%0d oe5=1 with new pull applied", k);
            end
            if (k == 1) begin
                n_checks++;
                if (pad_oe[5] !== 1'b0) begin n_fail++; $display("FAIL t3_oe_drop: got %b want 0", pad_oe[5]); end
            end
            if (k == 4) begin
                n_checks++;
                if ({pad_ie[5], pad_pd[5]} !== 2'b01) begin
                    n_fail++; $display("FAIL t3_t4: ie5/pd5=%b want 01", {pad_ie[5], pad_pd[5]});
                end
            end
            if (k == 5) begin
                n_checks++;
                if ({pad_ie[5], pad_pd[5], pad_pdrv[11:10], pad_oe[5]} !== 5'b10000) begin
                    n_fail++; $display("FAIL t3_t5: ie5/pd5/pdrv/oe5=%b want 10000", {pad_ie[5], pad_pd[5], pad_pdrv[11:10], pad_oe[5]});
                end
            end
            if (k == 9) begin
                n_checks++;
                if ({done, err, pad_oe[5]} !== 3'b100) begin
                    n_fail++; $display("FAIL t3_t9: done/err/oe5=%b want 100", {done, err, pad_oe[5]});
                end
            end
            if (k < 9) cyc(1);
        end
        e_oe = 12'h008; e_ie = 12'h020; e_pd = 12'h000; e_pdrv = 24'h000040;
        check_pads("t3_final");
        cyc(1);
    endtask

    task automatic test_safe_abort();
        issue(4'd1, 8'h12);
        cyc(2);
        n_checks++;
        if (busy_idx !== 4'd1) begin n_fail++; $display("FAIL t4_busy: got %0d want 1", busy_idx); end
        safe_i = 1'b1;
        cyc(1);
        safe_i = 1'b0;
        n_checks++;
        if ({pad_oe[3], cfg_ready} !== 2'b10) begin
            n_fail++; $display("FAIL t4_t4: oe3/ready=%b want 10", {pad_oe[3], cfg_ready});
        end
        cyc(1);
        n_checks++;
        if (pad_oe !== 12'h000) begin n_fail++; $display("FAIL t4_oe_off: got %h want 000", pad_oe); end
        n_checks++;
        if ({done, err, pad_ie[1], pad_oe[1], busy_idx} !== {4'b1100, 4'd0}) begin
            n_fail++; $display("FAIL t4_abort: done/err/ie1/oe1/busy=%b want 11000000", {done, err, pad_ie[1], pad_oe[1], busy_idx});
        end
        n_checks++;
        if ({pad_pu, pad_ie} !== {12'h008, 12'h020}) begin
            n_fail++; $display("FAIL t4_hold: pu=%h ie=%h want pu=008 ie=020", pad_pu, pad_ie);
        end
        cyc(1);
        n_checks++;
        if ({pad_oe, done} !== {12'h008, 1'b0}) begin
            n_fail++; $display("FAIL t4_restore: oe=%h done=%b want oe=008 done=0", pad_oe, done);
        end
        n_checks++;
        if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL t4_ready: got %b want 1", cfg_ready); end
    endtask

    task automatic test_back_to_back();
        cfg_idx = 4'd0; cfg_word = 8'h02; cfg_valid = 1'b1;
        cyc(1);
        cfg_idx = 4'd7; cfg_word = 8'hE2;
        n_checks++;
        if ({busy_idx, cfg_ready, pad_oe[0]} !== 6'b0) begin
            n_fail++; $display("FAIL t5_first: busy/ready/oe0=%b want 000000", {busy_idx, cfg_ready, pad_oe[0]});
        end
        cyc(7);
        n_checks++;
        if ({done, cfg_ready} !== 2'b00) begin
            n_fail++; $display("FAIL t5_t8: done/ready=%b want 00", {done, cfg_ready});
        end
        cyc(1);
        n_checks++;
        if ({done, cfg_ready, pad_oe[0]} !== 3'b111) begin
            n_fail++; $display("FAIL t5_t9: done/ready/oe0=%b want 111", {done, cfg_ready, pad_oe[0]});
        end
        cyc(1);
        cfg_valid = 1'b0;
        n_checks++;
        if ({busy_idx, done, cfg_ready, pad_oe[7]} !== {4'd7, 3'b000}) begin
            n_fail++; $display("FAIL t5_second: busy/done/ready/oe7=%b want 0111000", {busy_idx, done, cfg_ready, pad_oe[7]});
        end
        cyc(8);
        n_checks++;
        if ({done, err, pad_oe[7]} !== 3'b101) begin
            n_fail++; $display("FAIL t5_done2: done/err/oe7=%b want 101", {done, err, pad_oe[7]});
        end
        e_oe = 12'h089; e_cs = 12'h080; e_sl = 12'h080; e_pdrv = 24'h008040;
        check_pads("t5_final");
        cyc(1);
    endtask

    task automatic test_reset_mid_seq();
        issue(4'd9, 8'h16);
        cyc(5);
        RST = 1'b1;
        #1;
        e_cs = '0; e_sl = '0; e_ie = '0; e_oe = '0; e_pu = '0; e_pd = '0; e_pdrv = '0;
        check_pads("t6_async_pads");
        n_checks++;
        if ({done, err, busy_idx, cfg_ready} !== 7'b0) begin
            n_fail++; $display("FAIL t6_async_ctl: got %b want 0000000", {done, err, busy_idx, cfg_ready});
        end
        cyc(2);
        RST = 1'b0;
        cyc(1);
        n_checks++;
        if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL t6_ready: got %b want 1", cfg_ready); end
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if ({done, pad_oe, busy_idx} !== 17'b0) begin
                n_fail++; $display("FAIL t6_no_resume: cycle %0d done=%b oe=%h busy=%0d want all 0", k, done, pad_oe, busy_idx);
            end
            cyc(1);
        end
    endtask

    initial begin
        test_reset();
        test_basic_seq();
        test_reject();
        test_out_to_in();
        test_safe_abort();
        test_back_to_back();
        test_reset_mid_seq();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
